// File: rtl/demux_sched_pkg.sv
// rtl/demux_sched_pkg.sv - shared constants, state type and counter helper for demux_rr_scheduler
//
// Purpose: common definitions for the packet scheduler slice.
//   NUM_CH        number of demux output channels
//   SEL_W         width of a channel select
//   state_t       scheduler FSM state (IDLE, BUSY)
//   cnt_saturated 1 when a packet count has reached all-ones for its width

package demux_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counters are passed zero-extended so one helper serves any width up to 32.
  function automatic logic cnt_saturated(input logic [31:0] cnt, input int w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (cnt >= max_val);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin picker
//
// Purpose: choose the first enabled channel at or after ptr, wrapping mod 4.
// Ports:
//   mask       in  4  bit i = 1: channel i may be picked
//   ptr        in  2  highest-priority channel
//   grant      out 2  picked channel (don't-care when any_valid = 0)
//   any_valid  out 1  at least one channel enabled

module rr_pick4
  import demux_sched_pkg::*;
(
  input  logic [3:0]       mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any_valid
);

  logic [SEL_W-1:0] idx;

  assign any_valid = |mask;

  // Walk from the farthest offset back to ptr so the nearest enabled
  // channel is the last one written and therefore wins.
  always_comb begin
    grant = ptr;
    idx   = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (mask[idx]) begin
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// rtl/demux_rr_scheduler.sv - per-packet round-robin scheduler for a 1-to-4 demux
//
// Purpose: grant each input packet to one enabled output channel in round-robin
// order, hold the selection until the last beat is accepted, and count packets
// per channel with saturation.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   en_mask     in  4           channels allowed to receive a new packet
//   in_valid    in  1           input beat valid
//   in_data     in  DATA_W      input beat data
//   in_last     in  1           last beat of packet
//   in_ready    out 1           input beat accepted when in_valid & in_ready
//   out_valid   out 4           one-hot valid towards the selected channel
//   out_data    out DATA_W      shared data bus (copy of in_data)
//   out_last    out 1           copy of in_last
//   out_ready   in  4           per-channel ready
//   sel         out 2           current demux select
//   busy        out 1           packet in flight
//   pkt_cnt     out 4*CNT_W     channel i count at [i*CNT_W +: CNT_W]

module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            en_mask,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [3:0]            out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  input  logic [3:0]            out_ready,
  output logic [1:0]            sel,
  output logic                  busy,
  output logic [4*CNT_W-1:0]    pkt_cnt
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  logic [SEL_W-1:0] grant;
  logic             any_valid;
  logic             start;
  logic             done;

  rr_pick4 u_pick (
    .mask      (en_mask),
    .ptr       (ptr_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // Data path is a straight wire; out_valid alone qualifies it.
  assign out_data = in_data;
  assign out_last = in_last;
  assign sel      = sel_q;

  assign start = (state_q == IDLE) && in_valid && any_valid;
  assign done  = (state_q == BUSY) && in_valid && out_ready[sel_q] && in_last;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 4'b0000;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = BUSY;
      end
      BUSY: begin
        busy             = 1'b1;
        in_ready         = out_ready[sel_q];
        out_valid[sel_q] = in_valid;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      // sel is latched only at grant time so mask changes mid-packet are ignored.
      if (start) sel_q <= grant;
      if (done) begin
        ptr_q <= sel_q + SEL_W'(1);
        if (!cnt_saturated(32'(cnt_q[sel_q]), CNT_W)) begin
          cnt_q[sel_q] <= cnt_q[sel_q] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb/tb_demux_rr_scheduler.sv - directed self-checking bench for demux_rr_scheduler

module tb_demux_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en_mask;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  out_ready;
  logic [1:0]  sel;
  logic        busy;
  logic [31:0] pkt_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_rr_scheduler #(.DATA_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full packet with all out_ready high, starting in IDLE; occupies n+1 cycles.
  task automatic send_pkt(input int n, input logic [1:0] exp_sel, input logic [3:0] exp_oh);
    in_valid = 1'b1;
    in_data  = 8'h40 + 8'(exp_sel);
    in_last  = (n == 1);
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    step();
    for (int b = 0; b < n; b++) begin
      chk("pkt_busy", 32'(busy), 32'd1);
      chk("pkt_sel", 32'(sel), 32'(exp_sel));
      chk("pkt_out_valid", 32'(out_valid), 32'(exp_oh));
      chk("pkt_in_ready", 32'(in_ready), 32'd1);
      chk("pkt_out_data", 32'(out_data), 32'(in_data));
      step();
      if (b < n - 1) begin
        in_data = in_data + 8'h10;
        in_last = (b == n - 2);
      end
    end
    chk("pkt_end_idle", 32'(busy), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    en_mask   = 4'b0000;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 4'b1111;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    rst = 1'b0;
    step();

    // Four single-beat packets, full mask
    en_mask = 4'b1111;
    send_pkt(1, 2'd0, 4'b0001);
    send_pkt(1, 2'd1, 4'b0010);
    send_pkt(1, 2'd2, 4'b0100);
    send_pkt(1, 2'd3, 4'b1000);
    chk("cnt_after_rr4", pkt_cnt, 32'h01010101);

    // Sparse mask: 0,2,0
    en_mask = 4'b0101;
    send_pkt(2, 2'd0, 4'b0001);
    send_pkt(2, 2'd2, 4'b0100);
    send_pkt(2, 2'd0, 4'b0001);
    chk("cnt_after_0101", pkt_cnt, 32'h01020103);

    // 3-beat packet to channel 1 with 2-cycle backpressure on beat 2
    en_mask  = 4'b1111;
    in_valid = 1'b1;
    in_data  = 8'hA0;
    in_last  = 1'b0;
    step();
    chk("bp_sel", 32'(sel), 32'd1);
    chk("bp_out_valid", 32'(out_valid), 32'b0010);
    chk("bp_in_ready_b1", 32'(in_ready), 32'd1);
    step();
    in_data   = 8'hA1;
    out_ready = 4'b1101;
    #1;
    chk("bp_stall1_ready", 32'(in_ready), 32'd0);
    chk("bp_stall1_valid", 32'(out_valid), 32'b0010);
    step();
    chk("bp_stall2_ready", 32'(in_ready), 32'd0);
    chk("bp_stall2_sel", 32'(sel), 32'd1);
    chk("bp_stall2_data", 32'(out_data), 32'hA1);
    step();
    out_ready = 4'b1111;
    #1;
    chk("bp_resume_ready", 32'(in_ready), 32'd1);
    step();
    in_data = 8'hA2;
    in_last = 1'b1;
    #1;
    chk("bp_last_busy", 32'(busy), 32'd1);
    chk("bp_out_last", 32'(out_last), 32'd1);
    step();
    chk("bp_done", 32'(busy), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("cnt_after_bp", pkt_cnt, 32'h01020203);

    // Empty mask holds IDLE, then mask 1000 grants channel 3
    en_mask  = 4'b0000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("nomask_busy", 32'(busy), 32'd0);
      chk("nomask_in_ready", 32'(in_ready), 32'd0);
    end
    en_mask = 4'b1000;
    step();
    chk("mask8_busy", 32'(busy), 32'd1);
    chk("mask8_sel", 32'(sel), 32'd3);
    chk("mask8_out_valid", 32'(out_valid), 32'b1000);
    in_last = 1'b1;
    step();
    chk("mask8_done", 32'(busy), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Mask cleared mid-packet: packet finishes on channel 0, next waits
    en_mask  = 4'b1111;
    in_valid = 1'b1;
    step();
    chk("mclr_sel", 32'(sel), 32'd0);
    en_mask = 4'b0000;
    step();
    chk("mclr_busy", 32'(busy), 32'd1);
    chk("mclr_out_valid", 32'(out_valid), 32'b0001);
    in_last = 1'b1;
    step();
    chk("mclr_done", 32'(busy), 32'd0);
    in_last = 1'b0;
    step();
    chk("mclr_wait_busy", 32'(busy), 32'd0);
    chk("mclr_wait_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    chk("cnt_after_mclr", pkt_cnt, 32'h02020204);

    // Reset on beat 2 of a 4-beat packet to channel 1
    en_mask  = 4'b1111;
    in_valid = 1'b1;
    step();
    chk("rstm_sel", 32'(sel), 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_out_valid", 32'(out_valid), 32'd0);
    chk("rstm_in_ready", 32'(in_ready), 32'd0);
    chk("rstm_sel0", 32'(sel), 32'd0);
    chk("rstm_cnt", pkt_cnt, 32'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    send_pkt(1, 2'd0, 4'b0001);

    // Saturation on channel 0
    en_mask  = 4'b0001;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int p = 0; p < 253; p++) begin
      step();
      step();
    end
    chk("sat_254", 32'(pkt_cnt[7:0]), 32'd254);
    step();
    step();
    chk("sat_255", 32'(pkt_cnt[7:0]), 32'd255);
    for (int p = 0; p < 46; p++) begin
      step();
      step();
    end
    chk("sat_hold", pkt_cnt, 32'h000000FF);
    in_valid = 1'b0;
    in_last  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
